alu_sequencer: RTL and testbench

- Command-level controller for the 8-bit combinational ALU of the micro.
- Accepts one instruction at a time over a valid/ready handshake, reads operands from an internal 4x8 register file, and drives the ALU operand/opcode inputs.
- Captures the ALU result and flags, writes the result back, and signals completion.
- Adds a multi-cycle MUL macro-op, sequenced as shift-and-add iterations over the same ALU.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/seq_regfile.sv | 35 +++
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and flag layout for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam int FLG_ONES  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_SIGN  = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MADD = 3'd2,
    S_MSHL = 3'd3,
    S_MSHR = 3'd4,
    S_MWB  = 3'd5
  } state_e;

endpackage

// File: rtl/seq_regfile.sv
// Small register file: one synchronous write port, two operand read ports
// and a debug read port, all reads combinational.
module seq_regfile #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] ra_addr_i,
  output logic [DW-1:0] ra_data_o,
  input  logic [AW-1:0] rb_addr_i,
  output logic [DW-1:0] rb_data_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0][DW-1:0] mem_q;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n)                          mem_q[g] <= '0;
      else if (we_i && waddr_i == AW'(g))  mem_q[g] <= wdata_i;
    end
  end

  assign ra_data_o  = mem_q[ra_addr_i];
  assign rb_data_o  = mem_q[rb_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer around an external 8-bit ALU: single-cycle ops plus a
// shift-and-add MUL macro-op that reuses the same ALU for every step.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_AW    = 2,
  parameter int MUL_ITERS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_sa,
  input  logic [REG_AW-1:0] cmd_sb,
  input  logic              cmd_imm_en,
  input  logic [7:0]        cmd_imm,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  input  logic [7:0]        alu_r,
  input  logic [2:0]        alu_f,
  output logic              done,
  output logic              err,
  output logic [7:0]        result,
  output logic [2:0]        flags,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam int IW = $clog2(MUL_ITERS + 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [7:0]        a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [7:0]        result_q, result_d;
  logic [2:0]        flags_q, flags_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic              done_q, done_d, err_q, err_d;

  logic              we;
  logic [7:0]        wdata, ra_data, rb_data, b_in;
  logic              accept;

  seq_regfile #(.AW(REG_AW), .DW(8)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we),
    .waddr_i   (dst_q),
    .wdata_i   (wdata),
    .ra_addr_i (cmd_sa),
    .ra_data_o (ra_data),
    .rb_addr_i (cmd_sb),
    .rb_data_o (rb_data),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign b_in      = cmd_imm_en ? cmd_imm : rb_data;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we       = 1'b0;
    wdata    = alu_r;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_op   = OP_ADD;
    case (state_q)
      S_IDLE: if (accept) begin
        dst_d = cmd_dst;
        a_d   = ra_data;
        b_d   = b_in;
        if (cmd_op <= OP_NOT) begin
          op_d    = cmd_op[2:0];
          state_d = S_EXEC;
        end else if (cmd_op == OP_MUL) begin
          acc_d   = 8'h00;
          iter_d  = '0;
          state_d = (b_in == 8'h00) ? S_MWB : S_MADD;
        end else begin
          err_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_op   = {1'b0, op_q};
        we       = 1'b1;
        result_d = alu_r;
        flags_d  = alu_f;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_MADD: begin
        alu_a   = acc_q;
        alu_b   = a_q;
        alu_op  = OP_ADD;
        if (b_q[0]) acc_d = alu_r;
        state_d = S_MSHL;
      end
      S_MSHL: begin
        alu_a   = a_q;
        alu_b   = 8'h01;
        alu_op  = OP_SHL;
        a_d     = alu_r;
        state_d = S_MSHR;
      end
      S_MSHR: begin
        alu_a   = b_q;
        alu_b   = 8'h01;
        alu_op  = OP_SHR;
        b_d     = alu_r;
        iter_d  = iter_q + 1'b1;
        // Stop early once no multiplier bits remain.
        state_d = (alu_r == 8'h00 || iter_q == IW'(MUL_ITERS - 1)) ? S_MWB : S_MADD;
      end
      S_MWB: begin
        we                = 1'b1;
        wdata             = acc_q;
        result_d          = acc_q;
        flags_d           = 3'b000;
        flags_d[FLG_SIGN] = acc_q[7];
        done_d            = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, directed plan scenarios and a
// randomized command stream against an arithmetic reference model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_imm_en;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dst, cmd_sa, cmd_sb, dbg_addr;
  logic [7:0] cmd_imm, alu_a, alu_b, alu_r, result, dbg_data;
  logic [3:0] alu_op;
  logic [2:0] alu_f, flags;
  logic       done, err;

  always #10 clk = ~clk;

  alu_sequencer #(.REG_AW(2), .MUL_ITERS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_f(alu_f),
    .done(done), .err(err), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [8:0] alu9(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: return {1'b0, a} << b;
      4'd3: return {1'b0, a} >> b;
      4'd4: return {1'b0, a & b};
      4'd5: return {1'b0, a | b};
      4'd6: return {1'b0, a ^ b};
      4'd7: return {1'b0, ~a};
      default: return 9'h000;
    endcase
  endfunction

  logic [8:0] alu_res9;
  always_comb begin
    alu_res9 = alu9(alu_a, alu_b, alu_op);
    alu_r    = alu_res9[7:0];
    alu_f    = {alu_res9[7], alu_res9[8], &alu_res9};
  end

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mdl_reg [4];
  logic [7:0] mdl_result;
  logic [2:0] mdl_flags;
  int         exp_lat;
  bit         exp_ill;

  int          obs_lat, obs_err, obs_ndone;
  logic [15:0] obs_rdy, obs_opseen;

  task automatic model(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ie, input logic [7:0] imm);
    logic [7:0]  a, b, res;
    logic [15:0] p;
    logic [8:0]  r9;
    int          k;
    a = mdl_reg[sa];
    b = ie ? imm : mdl_reg[sb];
    exp_ill = 1'b0;
    if (op > 4'd8) begin
      exp_ill = 1'b1;
      exp_lat = 0;
    end else if (op == 4'd8) begin
      p   = 16'(a) * 16'(b);
      res = p[7:0];
      k   = 0;
      for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
      exp_lat      = 3 * k + 2;
      mdl_reg[dst] = res;
      mdl_result   = res;
      mdl_flags    = {res[7], 2'b00};
    end else begin
      r9           = alu9(a, b, op);
      exp_lat      = 2;
      mdl_reg[dst] = r9[7:0];
      mdl_result   = r9[7:0];
      mdl_flags    = {r9[7], r9[8], &r9};
    end
  endtask

  // Cycle 0 is the accept cycle; observation ends at the negedge of the done cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ie, input logic [7:0] imm,
                       input int hold, input int maxc);
    cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
    obs_lat = 0; obs_err = 0; obs_ndone = 0; obs_rdy = '0; obs_opseen = '0;
    @(posedge clk); #1;
    if (hold == 0) cmd_valid = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c < 16) obs_rdy[c] = cmd_ready;
      obs_opseen[alu_op] = 1'b1;
      if (err && obs_err == 0) obs_err = c;
      if (c >= hold) cmd_valid = 1'b0;
      if (done) begin obs_ndone++; obs_lat = c; break; end
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                     input logic [1:0] sb, input logic ie, input logic [7:0] imm);
    model(op, dst, sa, sb, ie, imm);
    issue(op, dst, sa, sb, ie, imm, 0, exp_ill ? 4 : 40);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_sa = '0; cmd_sb = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int r = 0; r < 4; r++) mdl_reg[r] = 8'h00;
    mdl_result = 8'h00; mdl_flags = 3'b000;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    vectors++; if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b want 00", {done, err}); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL reset_result: got %h want 00", result); end
    vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", flags); end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r); #1;
      vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL reset_reg%0d: got %h want 00", r, dbg_data); end
    end
  endtask

  task automatic test_add;
    run(OP_OR, 2'd0, 2'd0, 2'd0, 1'b1, 8'hF0);
    run(OP_OR, 2'd1, 2'd1, 2'd0, 1'b1, 8'h20);
    run(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00);
    vectors++; if (obs_lat !== 2) begin miscompares++; $display("FAIL add_latency: got %0d want 2", obs_lat); end
    vectors++; if (result !== 8'h10) begin miscompares++; $display("FAIL add_result: got %h want 10", result); end
    vectors++; if (flags !== 3'b010) begin miscompares++; $display("FAIL add_flags: got %b want 010", flags); end
    dbg_addr = 2'd2; #1;
    vectors++; if (dbg_data !== 8'h10) begin miscompares++; $display("FAIL add_r2: got %h want 10", dbg_data); end
  endtask

  task automatic test_sub;
    run(OP_AND, 2'd3, 2'd3, 2'd0, 1'b1, 8'h00);
    run(OP_OR, 2'd3, 2'd3, 2'd0, 1'b1, 8'h05);
    run(OP_SUB, 2'd2, 2'd3, 2'd0, 1'b1, 8'h07);
    vectors++; if (result !== 8'hFE) begin miscompares++; $display("FAIL sub_result: got %h want fe", result); end
    vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL sub_flags: got %b want 110", flags); end
    vectors++; if (obs_rdy[2:1] !== 2'b10) begin miscompares++; $display("FAIL sub_ready_c2c1: got %b want 10", obs_rdy[2:1]); end
  endtask

  task automatic test_mul;
    run(OP_AND, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00);
    run(OP_OR, 2'd0, 2'd0, 2'd0, 1'b1, 8'd13);
    run(OP_MUL, 2'd1, 2'd0, 2'd0, 1'b1, 8'd11);
    vectors++; if (obs_lat !== 14) begin miscompares++; $display("FAIL mul13_latency: got %0d want 14", obs_lat); end
    vectors++; if (result !== 8'h8F) begin miscompares++; $display("FAIL mul13_result: got %h want 8f", result); end
    vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL mul13_flags: got %b want 100", flags); end
    vectors++; if ((obs_opseen & ~16'h000D) !== 16'h0) begin miscompares++; $display("FAIL mul13_aluops: got %h want subset of 000d", obs_opseen); end
    dbg_addr = 2'd1; #1;
    vectors++; if (dbg_data !== 8'h8F) begin miscompares++; $display("FAIL mul13_r1: got %h want 8f", dbg_data); end
    run(OP_AND, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00);
    run(OP_OR, 2'd0, 2'd0, 2'd0, 1'b1, 8'd200);
    run(OP_MUL, 2'd1, 2'd0, 2'd0, 1'b1, 8'd3);
    vectors++; if (obs_lat !== 8) begin miscompares++; $display("FAIL mul200_latency: got %0d want 8", obs_lat); end
    vectors++; if (result !== 8'h58) begin miscompares++; $display("FAIL mul200_result: got %h want 58", result); end
    vectors++; if ((obs_opseen & ~16'h000D) !== 16'h0) begin miscompares++; $display("FAIL mul200_aluops: got %h want subset of 000d", obs_opseen); end
  endtask

  task automatic test_mul_zero;
    run(OP_MUL, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00);
    vectors++; if (obs_lat !== 2) begin miscompares++; $display("FAIL mul0_latency: got %0d want 2", obs_lat); end
    vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL mul0_result: got %h want 00", result); end
    vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL mul0_flags: got %b want 000", flags); end
    vectors++; if ((obs_opseen & ~16'h000D) !== 16'h0) begin miscompares++; $display("FAIL mul0_aluops: got %h want subset of 000d", obs_opseen); end
  endtask

  task automatic test_illegal;
    run(4'd9, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    vectors++; if (obs_err !== 1) begin miscompares++; $display("FAIL ill_err_cycle: got %0d want 1", obs_err); end
    vectors++; if (obs_ndone !== 0) begin miscompares++; $display("FAIL ill_done: got %0d want 0", obs_ndone); end
    vectors++; if (result !== mdl_result) begin miscompares++; $display("FAIL ill_result: got %h want %h", result, mdl_result); end
    vectors++; if (flags !== mdl_flags) begin miscompares++; $display("FAIL ill_flags: got %b want %b", flags, mdl_flags); end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r); #1;
      vectors++; if (dbg_data !== mdl_reg[r]) begin miscompares++; $display("FAIL ill_reg%0d: got %h want %h", r, dbg_data, mdl_reg[r]); end
    end
  endtask

  task automatic test_back_to_back;
    int nd;
    model(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01);
    issue(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 2, 40);
    vectors++; if (obs_lat !== 2) begin miscompares++; $display("FAIL busy_latency: got %0d want 2", obs_lat); end
    nd = 0;
    repeat (6) begin @(negedge clk); if (done) nd++; end
    vectors++; if (nd !== 0) begin miscompares++; $display("FAIL busy_extra_done: got %0d want 0", nd); end
    dbg_addr = 2'd0; #1;
    vectors++; if (dbg_data !== mdl_reg[0]) begin miscompares++; $display("FAIL busy_r0: got %h want %h", dbg_data, mdl_reg[0]); end
  endtask

  task automatic test_reset_mid_mul;
    int nd;
    run(OP_OR, 2'd0, 2'd0, 2'd0, 1'b1, 8'h81);
    cmd_op = OP_MUL; cmd_dst = 2'd3; cmd_sa = 2'd0; cmd_sb = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 8'hFF;
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int r = 0; r < 4; r++) mdl_reg[r] = 8'h00;
    mdl_result = 8'h00; mdl_flags = 3'b000;
    nd = 0;
    repeat (30) begin @(negedge clk); if (done) nd++; end
    vectors++; if (nd !== 0) begin miscompares++; $display("FAIL rstmul_done: got %0d want 0", nd); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rstmul_ready: got %b want 1", cmd_ready); end
    vectors++; if ({result, flags} !== 11'h0) begin miscompares++; $display("FAIL rstmul_res_flags: got %h want 0", {result, flags}); end
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r); #1;
      vectors++; if (dbg_data !== 8'h00) begin miscompares++; $display("FAIL rstmul_reg%0d: got %h want 00", r, dbg_data); end
    end
    run(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33);
    vectors++; if (obs_lat !== 2) begin miscompares++; $display("FAIL rstmul_add_latency: got %0d want 2", obs_lat); end
    vectors++; if (result !== 8'h33) begin miscompares++; $display("FAIL rstmul_add_result: got %h want 33", result); end
  endtask

  task automatic test_random;
    logic [3:0] op;
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 11));
      run(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if (exp_ill) begin
        vectors++; if (obs_err !== 1 || obs_ndone !== 0) begin miscompares++; $display("FAIL rnd%0d_illegal: got err@%0d done=%0d want err@1 done=0", n, obs_err, obs_ndone); end
      end else begin
        vectors++; if (obs_lat !== exp_lat) begin miscompares++; $display("FAIL rnd%0d_latency op%0d: got %0d want %0d", n, op, obs_lat, exp_lat); end
      end
      vectors++; if (result !== mdl_result) begin miscompares++; $display("FAIL rnd%0d_result op%0d: got %h want %h", n, op, result, mdl_result); end
      vectors++; if (flags !== mdl_flags) begin miscompares++; $display("FAIL rnd%0d_flags op%0d: got %b want %b", n, op, flags, mdl_flags); end
      for (int r = 0; r < 4; r++) begin
        dbg_addr = 2'(r); #1;
        vectors++; if (dbg_data !== mdl_reg[r]) begin miscompares++; $display("FAIL rnd%0d_reg%0d: got %h want %h", n, r, dbg_data, mdl_reg[r]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_mul_zero;
    test_illegal;
    test_back_to_back;
    test_reset_mid_mul;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
